// File: rtl/vector_engine.sv
// Vector renderer: CPU-loaded list RAM, Bresenham draw engine and a
// square framebuffer scanned by the display with per-read intensity decay.
module vector_engine #(
  parameter int VECTOR_RAM_WIDTH = 10,
  parameter int POINT_WIDTH      = 8,
  parameter int DECAY_STEP       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        pause,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic        vblank,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        write,
  input  logic        clear_overrun,
  output logic [7:0]  vector_r,
  output logic [7:0]  vector_g,
  output logic [7:0]  vector_b,
  output logic        vector_a,
  output logic        busy,
  output logic        overrun
);
  localparam int AW     = VECTOR_RAM_WIDTH;
  localparam int PW     = POINT_WIDTH;
  localparam int EW     = PW + 2;
  localparam int FW     = 2 * PW;
  localparam int STAGES = 1;
  localparam bit DECAY_EN = (DECAY_STEP != 0);
  localparam logic [9:0] FB_DIM = 10'(1 << PW);

  typedef enum logic [3:0] {
    IDLE, INIT, LOAD_LEN, ATTR, START_X, START_Y,
    POINT_X, POINT_Y, SETUP, DRAW, WAIT
  } state_t;

  // ---------------------------------------------------------------- list RAM
  logic [7:0]  list_ram [1 << AW];
  logic [AW:0] list_addr;   // MSB set once the walk has run off the end
  logic [7:0]  list_q;
  logic        unused_addr;

  assign unused_addr = &{1'b0, addr[15:AW]};

  // CPU write port and engine read port; engine sees data one clk after the address
  always_ff @(posedge clk) begin
    if (write) list_ram[addr[AW-1:0]] <= data_in;
    list_q <= list_ram[list_addr[AW-1:0]];
  end

  // CPU read-back, one clk latency
  always_ff @(posedge clk) begin
    if (reset) data_out <= 8'h00;
    else       data_out <= list_ram[addr[AW-1:0]];
  end

  // ------------------------------------------------------------ draw engine
  state_t               state, ret_state;
  logic [7:0]           seg_cnt, pix_attr;
  logic [PW-1:0]        x0, y0, x1, y1, cur_x, cur_y;
  logic signed [EW-1:0] err, dx, dy, err_nxt;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic                 sx, sy, step_x, step_y, at_end;
  logic [PW:0]          adx, ady;
  logic                 vbl_d, vbl_pend, vbl_rise, start_req, wrapped, is_fetch;
  logic                 plot_we;

  assign vbl_rise  = vblank & ~vbl_d;
  assign start_req = vbl_rise | vbl_pend;
  assign wrapped   = list_addr[AW];
  assign is_fetch  = (state inside {LOAD_LEN, ATTR, START_X, START_Y, POINT_X, POINT_Y});
  assign at_end    = (cur_x == x1) && (cur_y == y1);

  assign adx  = (x1 >= x0) ? {1'b0, x1 - x0} : {1'b0, x0 - x1};
  assign ady  = (y1 >= y0) ? {1'b0, y1 - y0} : {1'b0, y0 - y1};
  assign e2   = {err, 1'b0};
  assign dx_w = {dx[EW-1], dx};
  assign dy_w = {dy[EW-1], dy};
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  // Bresenham error update; both tests use the error before this step
  always_comb begin
    err_nxt = err;
    if (step_x) err_nxt = err_nxt + dy;
    if (step_y) err_nxt = err_nxt + dx;
  end

  // A restart request in the same clk abandons the pixel the engine was on
  assign plot_we = (state == DRAW) && !pause && !reset && !start_req;

  // Vblank edge detect and sticky overrun; a new overrun beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      vbl_d   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vbl_d <= vblank;
      if (vbl_rise && busy)   overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  // List walker / line stepper; pause freezes it but keeps a pending restart
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      list_addr <= '0;
      seg_cnt   <= '0;
      pix_attr  <= '0;
      busy      <= 1'b0;
      vbl_pend  <= 1'b0;
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      cur_x <= '0; cur_y <= '0;
      dx <= '0; dy <= '0; err <= '0;
      sx <= 1'b0; sy <= 1'b0;
    end else if (pause) begin
      if (vbl_rise) vbl_pend <= 1'b1;
    end else begin
      vbl_pend <= 1'b0;
      if (start_req) begin
        state <= INIT;
      end else if (is_fetch && wrapped) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: busy <= 1'b0;
          INIT: begin
            list_addr <= '0;
            busy      <= 1'b1;
            ret_state <= LOAD_LEN;
            state     <= WAIT;
          end
          WAIT: state <= ret_state;
          LOAD_LEN: begin
            if (list_q == 8'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              seg_cnt   <= list_q;
              list_addr <= list_addr + 1'b1;
              ret_state <= ATTR;
              state     <= WAIT;
            end
          end
          ATTR: begin
            pix_attr  <= list_q;
            list_addr <= list_addr + 1'b1;
            ret_state <= START_X;
            state     <= WAIT;
          end
          START_X: begin
            x0        <= list_q[PW-1:0];
            list_addr <= list_addr + 1'b1;
            ret_state <= START_Y;
            state     <= WAIT;
          end
          START_Y: begin
            y0        <= list_q[PW-1:0];
            list_addr <= list_addr + 1'b1;
            ret_state <= POINT_X;
            state     <= WAIT;
          end
          POINT_X: begin
            x1        <= list_q[PW-1:0];
            list_addr <= list_addr + 1'b1;
            ret_state <= POINT_Y;
            state     <= WAIT;
          end
          // next fetch is at least two clks away, so no WAIT needed here
          POINT_Y: begin
            y1        <= list_q[PW-1:0];
            list_addr <= list_addr + 1'b1;
            state     <= SETUP;
          end
          SETUP: begin
            cur_x <= x0;
            cur_y <= y0;
            sx    <= (x1 < x0);
            sy    <= (y1 < y0);
            dx    <= {1'b0, adx};
            dy    <= -$signed({1'b0, ady});
            err   <= $signed({1'b0, adx}) - $signed({1'b0, ady});
            state <= DRAW;
          end
          DRAW: begin
            if (at_end) begin
              x0      <= x1;
              y0      <= y1;
              seg_cnt <= seg_cnt - 8'd1;
              state   <= (seg_cnt == 8'd1) ? LOAD_LEN : POINT_X;
            end else begin
              err <= err_nxt;
              if (step_x) cur_x <= sx ? cur_x - 1'b1 : cur_x + 1'b1;
              if (step_y) cur_y <= sy ? cur_y - 1'b1 : cur_y + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ----------------------------------------------------- framebuffer/display
  logic [7:0]        fb [1 << FW];
  logic [FW-1:0]     rd_addr, wb_addr;
  logic [7:0]        rd_q, pix_d, dec_pix;
  logic [3:0]        dec_i;
  logic              active, act_p0, dec_we;
  logic [STAGES:0]   vld_pipe;

  assign active  = ({1'b0, hcnt} < FB_DIM) && ({1'b0, vcnt} < FB_DIM);
  assign rd_addr = {vcnt[PW-1:0], hcnt[PW-1:0]};
  assign dec_we  = vld_pipe[0] && act_p0 && DECAY_EN && !pause && !reset;

  // Saturating intensity decay; a fully faded pixel is cleared outright
  always_comb begin
    dec_i = 4'd0;
    if (int'(rd_q[3:0]) > DECAY_STEP) dec_i = rd_q[3:0] - 4'(DECAY_STEP);
    dec_pix = (dec_i == 4'd0) ? 8'h00 : {rd_q[7:4], dec_i};
  end

  // Decay write-back first so a same-address engine plot lands last and wins
  always_ff @(posedge clk) begin
    if (dec_we)  fb[wb_addr] <= dec_pix;
    if (plot_we) fb[{cur_y, cur_x}] <= pix_attr;
    rd_q <= fb[rd_addr];
  end

  // Display pipeline: read on ce_pix, hold pixel, then latch colour outputs
  always_ff @(posedge clk) begin
    act_p0  <= active;
    wb_addr <= rd_addr;
    pix_d   <= act_p0 ? rd_q : 8'h00;
  end

  function automatic logic [7:0] chan(input logic en, input logic dbl, input logic [3:0] i);
    logic [8:0] v;
    v = dbl ? {i, i, 1'b0} : {1'b0, i, i};
    if (!en) return 8'h00;
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Colour mapping: colour[2:0]==0 is white, colour[3] doubles brightness
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      vector_r <= 8'h00;
      vector_g <= 8'h00;
      vector_b <= 8'h00;
      vector_a <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ce_pix};
      if (vld_pipe[STAGES]) begin
        vector_r <= chan(pix_d[4] | ~|pix_d[6:4], pix_d[7], pix_d[3:0]);
        vector_g <= chan(pix_d[5] | ~|pix_d[6:4], pix_d[7], pix_d[3:0]);
        vector_b <= chan(pix_d[6] | ~|pix_d[6:4], pix_d[7], pix_d[3:0]);
        vector_a <= (pix_d != 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_vector_engine.sv
// Directed bench for vector_engine: list RAM, line drawing, decay, overrun,
// pause and reset. Pixels are observed through the display outputs.
`timescale 1ns/1ps
module tb_vector_engine;
  logic        clk = 1'b0;
  logic        reset, ce_pix, pause, vblank, write, clear_overrun;
  logic [8:0]  hcnt, vcnt;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out, vector_r, vector_g, vector_b;
  logic        vector_a, busy, overrun;
  logic [7:0]  lst[$];
  logic [24:0] px;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vector_engine dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .pause(pause),
    .hcnt(hcnt), .vcnt(vcnt), .vblank(vblank), .addr(addr),
    .data_in(data_in), .data_out(data_out), .write(write),
    .clear_overrun(clear_overrun), .vector_r(vector_r), .vector_g(vector_g),
    .vector_b(vector_b), .vector_a(vector_a), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic load_list();
    foreach (lst[i]) cpu_wr(16'(i), lst[i]);
  endtask

  task automatic vbl_pulse();
    vblank = 1'b1;
    tick(2);
    vblank = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_clks);
    for (int i = 0; i < max_clks && busy; i++) tick(1);
    chk(tag, 32'(busy), 32'd0);
  endtask

  // one display read of (x,y); hold=1 keeps pause high so the pixel is not decayed
  task automatic peek(input int x, input int y, input bit hold, output logic [24:0] o);
    logic pz;
    pz = pause;
    if (hold) pause = 1'b1;
    hcnt = 9'(x); vcnt = 9'(y); ce_pix = 1'b1;
    tick(1);
    ce_pix = 1'b0;
    tick(3);
    o = {vector_r, vector_g, vector_b, vector_a};
    pause = pz;
    hcnt = 9'd300; vcnt = 9'd300;
  endtask

  task automatic pk(input string tag, input int x, input int y, input logic [24:0] exp);
    logic [24:0] o;
    peek(x, y, 1'b1, o);
    chk(tag, 32'(o), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ok;
    reset = 1'b1; ce_pix = 1'b0; pause = 1'b0; vblank = 1'b0; write = 1'b0;
    clear_overrun = 1'b0; hcnt = 9'd300; vcnt = 9'd300; addr = '0; data_in = '0;
    tick(3);
    chk("reset", 32'({busy, overrun, vector_a, vector_r, vector_g, vector_b}), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);
    reset = 1'b0;
    tick(1);

    // CPU read-back
    cpu_wr(16'd3, 8'h55);
    addr = 16'd3; tick(1);
    chk("rd3", 32'(data_out), 32'h55);
    addr = 16'h0403; tick(1);
    chk("rd_alias", 32'(data_out), 32'h55);
    chk("busy_idle", 32'(busy), 32'd0);

    // horizontal red line (10..20,10)
    lst = '{8'd1, 8'h1F, 8'd10, 8'd10, 8'd20, 8'd10, 8'd0};
    load_list();
    vbl_pulse();
    chk("busy_up", 32'(busy), 32'd1);
    wait_idle("h_done", 40);
    pk("h_10", 10, 10, {8'hFF, 8'h00, 8'h00, 1'b1});
    pk("h_15", 15, 10, {8'hFF, 8'h00, 8'h00, 1'b1});
    pk("h_20", 20, 10, {8'hFF, 8'h00, 8'h00, 1'b1});
    pk("h_9",   9, 10, 25'd0);
    pk("h_21", 21, 10, 25'd0);
    pk("h_y11", 15, 11, 25'd0);

    // white diagonal (5,5)->(2,8)
    lst = '{8'd1, 8'h0A, 8'd5, 8'd5, 8'd2, 8'd8, 8'd0};
    load_list();
    vbl_pulse();
    wait_idle("d_done", 60);
    pk("d_55", 5, 5, {8'hAA, 8'hAA, 8'hAA, 1'b1});
    pk("d_46", 4, 6, {8'hAA, 8'hAA, 8'hAA, 1'b1});
    pk("d_37", 3, 7, {8'hAA, 8'hAA, 8'hAA, 1'b1});
    pk("d_28", 2, 8, {8'hAA, 8'hAA, 8'hAA, 1'b1});
    pk("d_45", 4, 5, 25'd0);
    pk("d_56", 5, 6, 25'd0);

    // steep doubled-green line (0,0)->(2,7)
    lst = '{8'd1, 8'hA3, 8'd0, 8'd0, 8'd2, 8'd7, 8'd0};
    load_list();
    vbl_pulse();
    wait_idle("s_done", 60);
    pk("s_00", 0, 0, {8'h00, 8'h66, 8'h00, 1'b1});
    pk("s_12", 1, 2, {8'h00, 8'h66, 8'h00, 1'b1});
    pk("s_15", 1, 5, {8'h00, 8'h66, 8'h00, 1'b1});
    pk("s_26", 2, 6, {8'h00, 8'h66, 8'h00, 1'b1});
    pk("s_27", 2, 7, {8'h00, 8'h66, 8'h00, 1'b1});
    pk("s_11", 1, 1, 25'd0);
    pk("s_25", 2, 5, 25'd0);

    // two chained segments, then a second list with a zero-length segment
    lst = '{8'd2, 8'h27, 8'd30, 8'd30, 8'd32, 8'd30, 8'd32, 8'd32,
            8'd1, 8'h47, 8'd40, 8'd40, 8'd40, 8'd40, 8'd0};
    load_list();
    vbl_pulse();
    wait_idle("m_done", 80);
    pk("m_3130", 31, 30, {8'h00, 8'h77, 8'h00, 1'b1});
    pk("m_3231", 32, 31, {8'h00, 8'h77, 8'h00, 1'b1});
    pk("m_3232", 32, 32, {8'h00, 8'h77, 8'h00, 1'b1});
    pk("m_4040", 40, 40, {8'h00, 8'h00, 8'h77, 1'b1});
    pk("m_4140", 41, 40, 25'd0);
    pk("m_4041", 40, 41, 25'd0);

    // decay: 0x13 read four times shows 0x13, 0x12, 0x11, then cleared
    lst = '{8'd1, 8'h13, 8'd50, 8'd50, 8'd50, 8'd50, 8'd0};
    load_list();
    vbl_pulse();
    wait_idle("k_done", 40);
    peek(50, 50, 1'b0, px); chk("k_rd1", 32'(px), 32'({8'h33, 8'h00, 8'h00, 1'b1}));
    peek(50, 50, 1'b0, px); chk("k_rd2", 32'(px), 32'({8'h22, 8'h00, 8'h00, 1'b1}));
    peek(50, 50, 1'b0, px); chk("k_rd3", 32'(px), 32'({8'h11, 8'h00, 8'h00, 1'b1}));
    peek(50, 50, 1'b0, px); chk("k_rd4", 32'(px), 32'd0);

    // overrun: long line still drawing at the next vblank
    lst = '{8'd1, 8'h01, 8'd0, 8'd100, 8'd255, 8'd100, 8'd0};
    load_list();
    vbl_pulse();
    tick(50);
    chk("o_pre", 32'(overrun), 32'd0);
    vbl_pulse();
    chk("o_set", 32'(overrun), 32'd1);
    chk("o_busy", 32'(busy), 32'd1);
    clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
    chk("o_clr", 32'(overrun), 32'd0);
    wait_idle("o_done", 400);
    pk("o_255", 255, 100, {8'h11, 8'h11, 8'h11, 1'b1});

    // pause mid-draw freezes the engine, then it resumes without a gap
    lst = '{8'd1, 8'h05, 8'd0, 8'd120, 8'd255, 8'd120, 8'd0};
    load_list();
    vbl_pulse();
    tick(30);
    pause = 1'b1;
    pk("p_5", 5, 120, {8'h55, 8'h55, 8'h55, 1'b1});
    pk("p_50a", 50, 120, 25'd0);
    tick(46);
    pk("p_50b", 50, 120, 25'd0);
    chk("p_busy", 32'(busy), 32'd1);
    pause = 1'b0;
    wait_idle("p_done", 400);
    n_ok = 0;
    for (int x = 0; x < 256; x++) begin
      peek(x, 120, 1'b1, px);
      if (px === {8'h55, 8'h55, 8'h55, 1'b1}) n_ok++;
    end
    chk("p_full", 32'(n_ok), 32'd256);

    // reset mid-draw aborts at once
    lst = '{8'd1, 8'h05, 8'd0, 8'd140, 8'd255, 8'd140, 8'd0};
    load_list();
    vbl_pulse();
    tick(25);
    pk("r_lit", 0, 120, {8'h55, 8'h55, 8'h55, 1'b1});
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("r_out", 32'({busy, overrun, vector_a, vector_r, vector_g, vector_b}), 32'd0);
    tick(300);
    chk("r_idle", 32'(busy), 32'd0);
    pk("r_200", 200, 140, 25'd0);
    pk("r_255", 255, 140, 25'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
